// File: rtl/carfield_apb_periph_decoder.sv
// carfield_apb_periph_decoder
// Registered APB demultiplexer for the Carfield peripheral window.
// It routes to CAN, the system timer, the advanced timer, the watchdog and the
// HyperBus config port.
//
// Each upstream setup phase is latched and decoded. The transfer is then
// re-issued downstream with a clean setup/access sequence, and the response is
// returned upstream for one cycle. Unmapped addresses and downstream stalls
// beyond TimeoutCycles access cycles produce an upstream error. The first such
// error is kept in a sticky log until err_clr_i.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   s_*                     upstream APB completer port
//   m_psel_o                one-hot downstream select (index = peripheral)
//   m_penable_o, m_pwrite_o, m_paddr_o, m_pwdata_o, m_pstrb_o, m_pprot_o
//                           shared registered downstream request
//   m_pready_i, m_pslverr_i, m_prdata_i
//                           per-peripheral responses
//   err_clr_i               clears the sticky error log
//   err_valid_o, err_timeout_o, err_addr_o
//                           sticky error log (first error only)
module carfield_apb_periph_decoder #(
    parameter bit          CanEnable     = 1'b1,
    parameter int          NumSlv        = 5,
    parameter int          AddrWidth     = 32,
    parameter int          DataWidth     = 32,
    // Packed arrays: the rightmost element is index 0 (CAN).
    parameter logic [NumSlv-1:0][AddrWidth-1:0] SlvBase = {
        32'h2000_8000, 32'h2000_7000, 32'h2000_5000, 32'h2000_4000, 32'h2000_1000},
    parameter logic [NumSlv-1:0][AddrWidth-1:0] SlvSize = {NumSlv{32'h0000_1000}},
    parameter int          TimeoutCycles = 256
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [AddrWidth-1:0]               s_paddr_i,
    input  logic                               s_psel_i,
    input  logic                               s_penable_i,
    input  logic                               s_pwrite_i,
    input  logic [DataWidth-1:0]               s_pwdata_i,
    input  logic [DataWidth/8-1:0]             s_pstrb_i,
    input  logic [2:0]                         s_pprot_i,
    output logic                               s_pready_o,
    output logic                               s_pslverr_o,
    output logic [DataWidth-1:0]               s_prdata_o,
    output logic [NumSlv-1:0]                  m_psel_o,
    output logic                               m_penable_o,
    output logic                               m_pwrite_o,
    output logic [AddrWidth-1:0]               m_paddr_o,
    output logic [DataWidth-1:0]               m_pwdata_o,
    output logic [DataWidth/8-1:0]             m_pstrb_o,
    output logic [2:0]                         m_pprot_o,
    input  logic [NumSlv-1:0]                  m_pready_i,
    input  logic [NumSlv-1:0]                  m_pslverr_i,
    input  logic [NumSlv-1:0][DataWidth-1:0]   m_prdata_i,
    input  logic                               err_clr_i,
    output logic                               err_valid_o,
    output logic                               err_timeout_o,
    output logic [AddrWidth-1:0]               err_addr_o
);

    localparam int IdxWidth = (NumSlv > 1) ? $clog2(NumSlv) : 1;
    localparam int CntWidth = $clog2(TimeoutCycles);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DN_SETUP  = 3'd1,
        DN_ACCESS = 3'd2,
        RESP      = 3'd3,
        ERR       = 3'd4
    } state_e;

    // Address decode: returns {hit, index}. The lowest matching index wins.
    // The compare is done one bit wider so base+size cannot wrap.
    function automatic logic [IdxWidth:0] decode(input logic [AddrWidth-1:0] addr);
        logic                hit;
        logic [IdxWidth-1:0] idx;
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < NumSlv; i++) begin
            if (!hit && (i != 0 || CanEnable) &&
                ({1'b0, addr} >= {1'b0, SlvBase[i]}) &&
                ({1'b0, addr} <  ({1'b0, SlvBase[i]} + {1'b0, SlvSize[i]}))) begin
                hit = 1'b1;
                idx = IdxWidth'(i);
            end
        end
        return {hit, idx};
    endfunction

    state_e                 state_q, state_d;
    logic [IdxWidth-1:0]    idx_q, idx_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [DataWidth/8-1:0] strb_q, strb_d;
    logic [2:0]             prot_q, prot_d;
    logic                   write_q, write_d;

    logic [NumSlv-1:0]      m_psel_q, m_psel_d;
    logic                   m_penable_q, m_penable_d;
    logic                   s_pready_q, s_pready_d;
    logic                   s_pslverr_q, s_pslverr_d;
    logic [DataWidth-1:0]   s_prdata_q, s_prdata_d;
    logic                   err_valid_q, err_valid_d;
    logic                   err_timeout_q, err_timeout_d;
    logic [AddrWidth-1:0]   err_addr_q, err_addr_d;

    logic [IdxWidth:0]      dec_s;
    logic                   timeout_s;

    assign dec_s = decode(s_paddr_i);

    // Next-state logic, request latching and access-phase timeout counter.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        prot_d    = prot_q;
        write_d   = write_q;
        timeout_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_psel_i && !s_penable_i) begin
                    addr_d  = s_paddr_i;
                    wdata_d = s_pwdata_i;
                    strb_d  = s_pstrb_i;
                    prot_d  = s_pprot_i;
                    write_d = s_pwrite_i;
                    if (dec_s[IdxWidth]) begin
                        idx_d   = dec_s[IdxWidth-1:0];
                        state_d = DN_SETUP;
                    end else begin
                        state_d = ERR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DN_SETUP: begin
                cnt_d   = '0;
                state_d = DN_ACCESS;
            end
            DN_ACCESS: begin
                if (m_pready_i[idx_q]) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
                    // The counter value marks the last allowed access cycle.
                    cnt_d     = '0;
                    timeout_s = 1'b1;
                    state_d   = ERR;
                end else begin
                    cnt_d = cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Output values computed from the next state so every output is a flop.
    always_comb begin
        m_psel_d      = '0;
        m_penable_d   = 1'b0;
        s_pready_d    = 1'b0;
        s_pslverr_d   = 1'b0;
        s_prdata_d    = '0;
        err_valid_d   = err_valid_q;
        err_timeout_d = err_timeout_q;
        err_addr_d    = err_addr_q;
        if (state_d == DN_SETUP || state_d == DN_ACCESS) begin
            m_psel_d    = {{(NumSlv-1){1'b0}}, 1'b1} << idx_d;
            m_penable_d = (state_d == DN_ACCESS);
        end else if (state_d == RESP) begin
            s_pready_d  = 1'b1;
            s_pslverr_d = m_pslverr_i[idx_q];
            s_prdata_d  = write_q ? '0 : m_prdata_i[idx_q];
        end else if (state_d == ERR) begin
            s_pready_d  = 1'b1;
            s_pslverr_d = 1'b1;
        end else begin
            m_psel_d = '0;
        end
        // Only the first error is logged. A clear in the same cycle as a new
        // error lets the new error through.
        if (state_d == ERR && (!err_valid_q || err_clr_i)) begin
            err_valid_d   = 1'b1;
            err_timeout_d = timeout_s;
            err_addr_d    = addr_d;
        end else if (err_clr_i) begin
            err_valid_d   = 1'b0;
            err_timeout_d = 1'b0;
            err_addr_d    = '0;
        end else begin
            err_valid_d = err_valid_q;
        end
    end

    // FSM state, latched request and timeout counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            prot_q  <= prot_d;
            write_q <= write_d;
        end
    end

    // Registered upstream response, downstream controls and error log.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_psel_q      <= '0;
            m_penable_q   <= 1'b0;
            s_pready_q    <= 1'b0;
            s_pslverr_q   <= 1'b0;
            s_prdata_q    <= '0;
            err_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_addr_q    <= '0;
        end else begin
            m_psel_q      <= m_psel_d;
            m_penable_q   <= m_penable_d;
            s_pready_q    <= s_pready_d;
            s_pslverr_q   <= s_pslverr_d;
            s_prdata_q    <= s_prdata_d;
            err_valid_q   <= err_valid_d;
            err_timeout_q <= err_timeout_d;
            err_addr_q    <= err_addr_d;
        end
    end

    assign s_pready_o    = s_pready_q;
    assign s_pslverr_o   = s_pslverr_q;
    assign s_prdata_o    = s_prdata_q;
    assign m_psel_o      = m_psel_q;
    assign m_penable_o   = m_penable_q;
    assign m_pwrite_o    = write_q;
    assign m_paddr_o     = addr_q;
    assign m_pwdata_o    = wdata_q;
    assign m_pstrb_o     = strb_q;
    assign m_pprot_o     = prot_q;
    assign err_valid_o   = err_valid_q;
    assign err_timeout_o = err_timeout_q;
    assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_carfield_apb_periph_decoder.sv
module tb_carfield_apb_periph_decoder;

    localparam int NS = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [31:0]        s_paddr;
    logic               s_psel, s_penable, s_pwrite;
    logic [31:0]        s_pwdata;
    logic [3:0]         s_pstrb;
    logic [2:0]         s_pprot;
    logic [NS-1:0]      m_pready, m_pslverr;
    logic [NS-1:0][31:0] m_prdata;
    logic               err_clr;

    logic               s_pready0, s_pslverr0, m_penable0, m_pwrite0;
    logic [31:0]        s_prdata0, m_paddr0, m_pwdata0, err_addr0;
    logic [NS-1:0]      m_psel0;
    logic [3:0]         m_pstrb0;
    logic [2:0]         m_pprot0;
    logic               err_valid0, err_timeout0;

    logic               s_pready1, s_pslverr1, m_penable1, m_pwrite1;
    logic [31:0]        s_prdata1, m_paddr1, m_pwdata1, err_addr1;
    logic [NS-1:0]      m_psel1;
    logic [3:0]         m_pstrb1;
    logic [2:0]         m_pprot1;
    logic               err_valid1, err_timeout1;

    carfield_apb_periph_decoder u_dut (
        .clk_i(clk), .rst_i(rst),
        .s_paddr_i(s_paddr), .s_psel_i(s_psel), .s_penable_i(s_penable),
        .s_pwrite_i(s_pwrite), .s_pwdata_i(s_pwdata), .s_pstrb_i(s_pstrb),
        .s_pprot_i(s_pprot), .s_pready_o(s_pready0), .s_pslverr_o(s_pslverr0),
        .s_prdata_o(s_prdata0), .m_psel_o(m_psel0), .m_penable_o(m_penable0),
        .m_pwrite_o(m_pwrite0), .m_paddr_o(m_paddr0), .m_pwdata_o(m_pwdata0),
        .m_pstrb_o(m_pstrb0), .m_pprot_o(m_pprot0), .m_pready_i(m_pready),
        .m_pslverr_i(m_pslverr), .m_prdata_i(m_prdata), .err_clr_i(err_clr),
        .err_valid_o(err_valid0), .err_timeout_o(err_timeout0), .err_addr_o(err_addr0)
    );

    carfield_apb_periph_decoder #(.CanEnable(1'b0)) u_dut_nocan (
        .clk_i(clk), .rst_i(rst),
        .s_paddr_i(s_paddr), .s_psel_i(s_psel), .s_penable_i(s_penable),
        .s_pwrite_i(s_pwrite), .s_pwdata_i(s_pwdata), .s_pstrb_i(s_pstrb),
        .s_pprot_i(s_pprot), .s_pready_o(s_pready1), .s_pslverr_o(s_pslverr1),
        .s_prdata_o(s_prdata1), .m_psel_o(m_psel1), .m_penable_o(m_penable1),
        .m_pwrite_o(m_pwrite1), .m_paddr_o(m_paddr1), .m_pwdata_o(m_pwdata1),
        .m_pstrb_o(m_pstrb1), .m_pprot_o(m_pprot1), .m_pready_i(m_pready),
        .m_pslverr_i(m_pslverr), .m_prdata_i(m_prdata), .err_clr_i(err_clr),
        .err_valid_o(err_valid1), .err_timeout_o(err_timeout1), .err_addr_o(err_addr1)
    );

    // Which instance the transfer task observes and answers.
    logic use_dut1 = 1'b0;
    wire [NS-1:0] sel_psel    = use_dut1 ? m_psel1    : m_psel0;
    wire          sel_penable = use_dut1 ? m_penable1 : m_penable0;
    wire          sel_pready  = use_dut1 ? s_pready1  : s_pready0;
    wire          sel_pslverr = use_dut1 ? s_pslverr1 : s_pslverr0;
    wire [31:0]   sel_prdata  = use_dut1 ? s_prdata1  : s_prdata0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] bases [NS] = '{32'h2000_1000, 32'h2000_4000, 32'h2000_5000,
                                32'h2000_7000, 32'h2000_8000};

    function automatic int ref_idx(input logic [31:0] a, input bit can_en);
        for (int i = 0; i < NS; i++) begin
            if ((i != 0 || can_en) && a >= bases[i] && a < bases[i] + 32'h1000)
                return i;
        end
        return -1;
    endfunction

    // Slave raises pready after wt wait cycles; the decoder gives up after 256 access cycles.
    function automatic int ref_lat(input int idx, input int wt);
        if (idx < 0) return 1;
        if (wt >= 256) return 258;
        return 3 + wt;
    endfunction

    logic        mv, mt;
    logic [31:0] ma;

    task automatic model_err(input bit is_err, input bit is_to, input logic [31:0] a, input bit clr);
        if (is_err && (!mv || clr)) begin
            mv = 1'b1; mt = is_to; ma = a;
        end else if (clr) begin
            mv = 1'b0; mt = 1'b0; ma = 32'h0;
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          wt;
        logic        serr;
        logic [31:0] rdata;
        int          exp_lat;
        logic [4:0]  exp_psel;
        logic        exp_perr;
        logic [31:0] exp_prdata;
    } vec_t;

    // One upstream transfer with a downstream slave model, bounded to 400 cycles.
    task automatic xfer(input vec_t v, input bit clr0,
                        output int lat, output logic [31:0] prd, output logic perr,
                        output logic [4:0] psel_seen, output int acc,
                        output logic [31:0] paddr_s, output logic [31:0] pwdata_s,
                        output logic [3:0] pstrb_s, output logic pwrite_s);
        int cyc;
        bit done;
        lat = -1; prd = 32'h0; perr = 1'b0; psel_seen = 5'h0; acc = 0;
        paddr_s = 32'h0; pwdata_s = 32'h0; pstrb_s = 4'h0; pwrite_s = 1'b0;
        cyc = 0; done = 1'b0;
        @(negedge clk);
        s_paddr = v.addr; s_pwrite = v.wr; s_pwdata = v.wdata; s_pstrb = v.strb;
        s_pprot = 3'b010; s_psel = 1'b1; s_penable = 1'b0; err_clr = clr0;
        m_prdata = {NS{v.rdata}}; m_pready = 5'h0; m_pslverr = 5'h0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            err_clr = 1'b0;
            s_penable = 1'b1;
            psel_seen |= sel_psel;
            if (sel_penable) begin
                acc++;
                if (acc == 1) begin
                    paddr_s = use_dut1 ? m_paddr1 : m_paddr0;
                    pwdata_s = use_dut1 ? m_pwdata1 : m_pwdata0;
                    pstrb_s = use_dut1 ? m_pstrb1 : m_pstrb0;
                    pwrite_s = use_dut1 ? m_pwrite1 : m_pwrite0;
                end
                m_pready  = (acc > v.wt) ? sel_psel : 5'h0;
                m_pslverr = (acc > v.wt && v.serr) ? sel_psel : 5'h0;
            end else begin
                m_pready = 5'h0; m_pslverr = 5'h0;
            end
            if (sel_pready) begin
                lat = cyc; prd = sel_prdata; perr = sel_pslverr; done = 1'b1;
            end
        end
        s_psel = 1'b0; s_penable = 1'b0; m_pready = 5'h0; m_pslverr = 5'h0;
    endtask

    // Apply one vector to the default instance and compare against its expectations and the log model.
    task automatic apply(input string tag, input vec_t v, input bit clr0);
        int lat, acc, idx;
        logic [31:0] prd, pa, pw;
        logic perr, pwr;
        logic [4:0] ps;
        logic [3:0] pst;
        xfer(v, clr0, lat, prd, perr, ps, acc, pa, pw, pst, pwr);
        check({tag, "_lat"}, 64'(lat), 64'(v.exp_lat));
        check({tag, "_psel"}, 64'(ps), 64'(v.exp_psel));
        check({tag, "_pslverr"}, 64'(perr), 64'(v.exp_perr));
        check({tag, "_prdata"}, 64'(prd), 64'(v.exp_prdata));
        if (v.exp_psel != 5'h0) begin
            check({tag, "_acc_cycles"}, 64'(acc), 64'(v.exp_lat - 2));
            check({tag, "_m_paddr"}, 64'(pa), 64'(v.addr));
            check({tag, "_m_pwdata"}, 64'(pw), 64'(v.wdata));
            check({tag, "_m_pstrb"}, 64'(pst), 64'(v.strb));
            check({tag, "_m_pwrite"}, 64'(pwr), 64'(v.wr));
        end
        idx = ref_idx(v.addr, 1'b1);
        model_err(idx < 0 || v.wt >= 256, idx >= 0 && v.wt >= 256, v.addr, clr0);
        check({tag, "_err_valid"}, 64'(err_valid0), 64'(mv));
        check({tag, "_err_timeout"}, 64'(err_timeout0), 64'(mt));
        check({tag, "_err_addr"}, 64'(err_addr0), 64'(ma));
    endtask

    vec_t tbl [12];

    initial begin
        vec_t v;
        int lat, acc, idx, r, j;
        logic [31:0] prd, pa, pw, a;
        logic perr, pwr;
        logic [4:0] ps;
        logic [3:0] pst;

        tbl[0]  = '{32'h2000_4010, 1'b0, 32'h0,         4'hF, 0,    1'b0, 32'hCAFE_0001, 3,   5'b00010, 1'b0, 32'hCAFE_0001};
        tbl[1]  = '{32'h2000_8FFC, 1'b1, 32'hA5A5_A5A5, 4'hF, 10,   1'b0, 32'h1111_1111, 13,  5'b10000, 1'b0, 32'h0};
        tbl[2]  = '{32'h2000_2000, 1'b0, 32'h0,         4'hF, 0,    1'b0, 32'h2222_2222, 1,   5'b00000, 1'b1, 32'h0};
        tbl[3]  = '{32'h2000_7000, 1'b0, 32'h0,         4'hF, 1000, 1'b0, 32'h3333_3333, 258, 5'b01000, 1'b1, 32'h0};
        tbl[4]  = '{32'h2000_1000, 1'b0, 32'h0,         4'h3, 0,    1'b1, 32'h0BAD_F00D, 3,   5'b00001, 1'b1, 32'h0BAD_F00D};
        tbl[5]  = '{32'h2000_1FFF, 1'b1, 32'h1234_5678, 4'h1, 2,    1'b0, 32'h4444_4444, 5,   5'b00001, 1'b0, 32'h0};
        tbl[6]  = '{32'h2000_4FFF, 1'b0, 32'h0,         4'hF, 1,    1'b0, 32'h1111_2222, 4,   5'b00010, 1'b0, 32'h1111_2222};
        tbl[7]  = '{32'h2000_5000, 1'b0, 32'h0,         4'hF, 0,    1'b0, 32'h3333_4444, 3,   5'b00100, 1'b0, 32'h3333_4444};
        tbl[8]  = '{32'h2000_6000, 1'b1, 32'h5555_5555, 4'hF, 0,    1'b0, 32'h0,         1,   5'b00000, 1'b1, 32'h0};
        tbl[9]  = '{32'h2000_9000, 1'b0, 32'h0,         4'hF, 0,    1'b0, 32'h6666_6666, 1,   5'b00000, 1'b1, 32'h0};
        tbl[10] = '{32'h2000_0FFF, 1'b0, 32'h0,         4'hF, 0,    1'b0, 32'h7777_7777, 1,   5'b00000, 1'b1, 32'h0};
        tbl[11] = '{32'h2000_7FFF, 1'b1, 32'hDEAD_BEEF, 4'hC, 3,    1'b0, 32'h8888_8888, 6,   5'b01000, 1'b0, 32'h0};

        rst = 1'b1; s_paddr = 32'h0; s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
        s_pwdata = 32'h0; s_pstrb = 4'h0; s_pprot = 3'h0; m_pready = 5'h0;
        m_pslverr = 5'h0; m_prdata = '0; err_clr = 1'b0;
        mv = 1'b0; mt = 1'b0; ma = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_s_pready", 64'(s_pready0), 64'h0);
        check("rst_s_pslverr", 64'(s_pslverr0), 64'h0);
        check("rst_s_prdata", 64'(s_prdata0), 64'h0);
        check("rst_m_psel", 64'(m_psel0), 64'h0);
        check("rst_m_penable", 64'(m_penable0), 64'h0);
        check("rst_m_paddr", 64'(m_paddr0), 64'h0);
        check("rst_err_valid", 64'(err_valid0), 64'h0);
        check("rst_err_addr", 64'(err_addr0), 64'h0);
        rst = 1'b0;

        // CAN window disabled: decode error on the second instance.
        use_dut1 = 1'b1;
        v = '{32'h2000_1000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h9999_9999, 1, 5'b00000, 1'b1, 32'h0};
        xfer(v, 1'b0, lat, prd, perr, ps, acc, pa, pw, pst, pwr);
        check("nocan_lat", 64'(lat), 64'd1);
        check("nocan_psel", 64'(ps), 64'h0);
        check("nocan_pslverr", 64'(perr), 64'h1);
        check("nocan_err_valid", 64'(err_valid1), 64'h1);
        check("nocan_err_timeout", 64'(err_timeout1), 64'h0);
        check("nocan_err_addr", 64'(err_addr1), 64'h2000_1000);
        use_dut1 = 1'b0;
        // The default instance is left stalled on CAN; reset both.
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 12; i++) apply($sformatf("tbl%0d", i), tbl[i], 1'b0);
        check("log_kept_after_timeout", 64'(err_addr0), 64'h2000_2000);

        // Clear the log.
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        model_err(1'b0, 1'b0, 32'h0, 1'b1);
        check("clr_err_valid", 64'(err_valid0), 64'h0);
        check("clr_err_timeout", 64'(err_timeout0), 64'h0);
        check("clr_err_addr", 64'(err_addr0), 64'h0);

        // Timeout into an empty log, then a decode error must not overwrite it.
        apply("to_empty", tbl[3], 1'b0);
        check("to_empty_timeout_flag", 64'(err_timeout0), 64'h1);
        apply("after_to", tbl[2], 1'b0);
        check("after_to_addr", 64'(err_addr0), 64'h2000_7000);
        // Clear coinciding with a new decode error: the new error is logged.
        apply("clr_set", tbl[8], 1'b1);
        check("clr_set_addr", 64'(err_addr0), 64'h2000_6000);

        // Reset in the middle of an access phase.
        @(negedge clk);
        s_paddr = 32'h2000_7000; s_pwrite = 1'b0; s_psel = 1'b1; s_penable = 1'b0;
        @(negedge clk); s_penable = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_psel_before", 64'(m_psel0), 64'b01000);
        check("mid_penable_before", 64'(m_penable0), 64'h1);
        rst = 1'b1;
        #1;
        check("mid_psel_rst", 64'(m_psel0), 64'h0);
        check("mid_penable_rst", 64'(m_penable0), 64'h0);
        check("mid_pready_rst", 64'(s_pready0), 64'h0);
        @(negedge clk);
        s_psel = 1'b0; s_penable = 1'b0;
        check("mid_pready_hold", 64'(s_pready0), 64'h0);
        rst = 1'b0;
        model_err(1'b0, 1'b0, 32'h0, 1'b1);
        apply("post_rst", tbl[7], 1'b0);

        // Randomized transfers against the reference model.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 3);
            j = $urandom_range(0, NS - 1);
            case (r)
                0:       a = 32'h2000_0000 + 32'($urandom_range(0, 32'h9FFF));
                1:       a = bases[j];
                2:       a = bases[j] + 32'h0FFF;
                default: a = bases[j] + 32'h1000;
            endcase
            v.addr  = a;
            v.wr    = 1'($urandom_range(0, 1));
            v.wdata = $urandom;
            v.strb  = 4'($urandom_range(0, 15));
            v.wt    = ($urandom_range(0, 9) == 0) ? 300 : $urandom_range(0, 6);
            v.serr  = 1'($urandom_range(0, 1));
            v.rdata = $urandom;
            idx = ref_idx(a, 1'b1);
            v.exp_lat    = ref_lat(idx, v.wt);
            v.exp_psel   = (idx < 0) ? 5'h0 : (5'b00001 << idx);
            v.exp_perr   = (idx < 0) || (v.wt >= 256) || v.serr;
            v.exp_prdata = (idx >= 0 && v.wt < 256 && !v.wr) ? v.rdata : 32'h0;
            apply($sformatf("rnd%0d", n), v, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
